// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, WAIT = 2'b10, RESP = 2'b11} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;
  localparam logic [2:0] IF_FUNCT3 = 3'b010;

  // Bits needed to hold LAT-1 (the value loaded into the latency counter).
  function automatic int cnt_width(input int lat);
    return (lat < 2) ? 1 : $clog2(lat);
  endfunction
endpackage

// File: rtl/unified_mem_arbiter_lat_counter.sv
// Loadable down-counter; done is high while the count sits at zero.
module lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates IF and load/store requests onto one single-port memory with
// fixed read latency; one transaction in flight, IF protected from starvation.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int n        = 32,
  parameter int AW       = 6,
  parameter int LAT      = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [n-1:0]  if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [n-1:0]  d_wdata,
  input  logic [2:0]    d_funct3,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [n-1:0]  d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [n-1:0]  mem_wdata,
  output logic [2:0]    mem_funct3,
  input  logic [n-1:0]  mem_rdata,
  output logic          busy
);
  localparam int CW = cnt_width(LAT);
  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [n-1:0]  wdata_q, wdata_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d, mem_en_q, mem_en_d;
  logic          if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d, busy_q, busy_d;
  logic [n-1:0]  if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic          if_win, d_win, cnt_load, cnt_dec, cnt_done;

  assign if_win = if_req && (!d_req || starve_q == STARVE_MAX);
  assign d_win  = d_req && !if_win;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    starve_d    = starve_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    mem_en_d    = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_win || d_win) begin
          owner_d  = if_win ? OWN_IF : OWN_D;
          addr_d   = if_win ? if_addr : d_addr;
          we_d     = if_win ? 1'b0 : d_we;
          wdata_d  = if_win ? '0 : d_wdata;
          funct3_d = if_win ? IF_FUNCT3 : d_funct3;
          if_gnt_d = if_win;
          d_gnt_d  = d_win;
          mem_en_d = 1'b1;
          state_d  = ACCESS;
        end
        if (!if_req || if_win)                 starve_d = '0;
        else if (d_win && starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
      end
      ACCESS: begin
        if (we_q) state_d = IDLE;
        else begin
          cnt_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) begin
          state_d = RESP;
          if (owner_q == OWN_IF) begin
            if_rdata_d  = mem_rdata;
            if_rvalid_d = 1'b1;
          end else begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      starve_q    <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      starve_q    <= starve_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      mem_en_q    <= mem_en_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  lat_counter #(.W(CW)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CW'(LAT - 1)),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  assign if_gnt     = if_gnt_q;
  assign d_gnt      = d_gnt_q;
  assign if_rvalid  = if_rvalid_q;
  assign d_rvalid   = d_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_en_q & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_funct3 = funct3_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model; LAT=1/4 instances share the inputs for latency checks.
module tb_unified_mem_arbiter;
  localparam int LAT = 2;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [5:0] if_addr = 0, d_addr = 0;
  logic [31:0] d_wdata = 0;
  logic [2:0] d_funct3 = 0;

  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [5:0] mem_addr;
  logic [2:0] mem_funct3;
  logic a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_if_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
  logic [5:0] a_mem_addr;
  logic [2:0] a_mem_funct3;
  logic b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic [5:0] b_mem_addr;
  logic [2:0] b_mem_funct3;

  int n_chk = 0, n_pass = 0;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] p2 [2];
  logic [31:0] p4 [4];
  logic [31:0] p1;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.n(32), .AW(6), .LAT(LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .mem_rdata(mem_rdata), .busy(busy));

  unified_mem_arbiter #(.n(32), .AW(6), .LAT(1), .MAX_WAIT(MAX_WAIT)) dut_l1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3), .d_gnt(a_d_gnt),
    .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata), .mem_en(a_mem_en), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_funct3(a_mem_funct3),
    .mem_rdata(a_mem_rdata), .busy(a_busy));

  unified_mem_arbiter #(.n(32), .AW(6), .LAT(4), .MAX_WAIT(MAX_WAIT)) dut_l4 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata), .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3), .d_gnt(b_d_gnt),
    .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_funct3(b_mem_funct3),
    .mem_rdata(b_mem_rdata), .busy(b_busy));

  // Memory: only the LAT=2 instance writes; each instance gets its own read pipe
  // that returns garbage except exactly LAT cycles after a read strobe.
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    p2[0] <= (mem_en && !mem_we) ? mem[mem_addr] : $urandom;
    p2[1] <= p2[0];
    p1    <= (a_mem_en && !a_mem_we) ? mem[a_mem_addr] : $urandom;
    p4[0] <= (b_mem_en && !b_mem_we) ? mem[b_mem_addr] : $urandom;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign mem_rdata   = p2[1];
  assign a_mem_rdata = p1;
  assign b_mem_rdata = p4[3];

  task automatic do_reset();
    rst = 1; if_req = 0; d_req = 0; d_we = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++;
    if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we} !== 6'b0)
      $display("FAIL reset_strobes: got %b want 0", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we});
    else n_pass++;
    n_chk++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata, mem_funct3} !== '0)
      $display("FAIL reset_data: got %h want 0", {if_rdata, d_rdata, mem_addr, mem_wdata, mem_funct3});
    else n_pass++;
    n_chk++;
    if ({a_if_gnt, a_if_rvalid, a_d_gnt, a_d_rvalid, a_mem_en, a_mem_we, a_busy, a_if_rdata, a_d_rdata,
         a_mem_addr, a_mem_wdata, a_mem_funct3} !== '0)
      $display("FAIL reset_lat1: got nonzero outputs want 0");
    else n_pass++;
    n_chk++;
    if ({b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy, b_if_rdata, b_d_rdata,
         b_mem_addr, b_mem_wdata, b_mem_funct3} !== '0)
      $display("FAIL reset_lat4: got nonzero outputs want 0");
    else n_pass++;
    rst = 0;
  endtask

  task automatic test_fetch_latency();
    int rv2 = -1, rv1 = -1, rv4 = -1;
    do_reset();
    mem[5] = 32'h00500093;
    if_req = 1; if_addr = 6'h05;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) begin
        n_chk++;
        if ({if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_funct3} !== {4'b1010, 6'h05, 3'b010})
          $display("FAIL fetch_access: got %b_%h_%b want 1010_05_010", {if_gnt, d_gnt, mem_en, mem_we}, mem_addr, mem_funct3);
        else n_pass++;
        if_req = 0;
      end
      if (c == 6) begin
        n_chk++; if (busy !== 1'b0) $display("FAIL fetch_busy_c6: got %b want 0", busy); else n_pass++;
      end
      if (if_rvalid && rv2 < 0) begin
        rv2 = c;
        n_chk++; if (if_rdata !== 32'h00500093) $display("FAIL fetch_data_l2: got %h want 00500093", if_rdata); else n_pass++;
      end
      if (a_if_rvalid && rv1 < 0) begin
        rv1 = c;
        n_chk++; if (a_if_rdata !== 32'h00500093) $display("FAIL fetch_data_l1: got %h want 00500093", a_if_rdata); else n_pass++;
      end
      if (b_if_rvalid && rv4 < 0) begin
        rv4 = c;
        n_chk++; if (b_if_rdata !== 32'h00500093) $display("FAIL fetch_data_l4: got %h want 00500093", b_if_rdata); else n_pass++;
      end
    end
    n_chk++; if (rv2 != 5) $display("FAIL fetch_rvalid_l2: got cycle %0d want 5", rv2); else n_pass++;
    n_chk++; if (rv1 != 4) $display("FAIL fetch_rvalid_l1: got cycle %0d want 4", rv1); else n_pass++;
    n_chk++; if (rv4 != 7) $display("FAIL fetch_rvalid_l4: got cycle %0d want 7", rv4); else n_pass++;
  endtask

  task automatic test_both();
    int dg = -1, dv = -1, ig = -1, iv = -1;
    logic [31:0] dd, id;
    do_reset();
    dd = $urandom; id = $urandom;
    mem[6'h10] = dd; mem[6'h22] = id;
    if_req = 1; if_addr = 6'h22;
    d_req = 1; d_we = 0; d_addr = 6'h10; d_funct3 = 3'b100;
    for (int c = 2; c <= 14; c++) begin
      @(negedge clk);
      if (d_gnt && dg < 0) begin dg = c; d_req = 0; end
      if (if_gnt && ig < 0) begin ig = c; if_req = 0; end
      if (d_rvalid && dv < 0) begin
        dv = c;
        n_chk++; if (d_rdata !== dd) $display("FAIL both_ddata: got %h want %h", d_rdata, dd); else n_pass++;
      end
      if (if_rvalid && iv < 0) begin
        iv = c;
        n_chk++; if (if_rdata !== id) $display("FAIL both_idata: got %h want %h", if_rdata, id); else n_pass++;
      end
    end
    if_req = 0; d_req = 0;
    n_chk++; if (dg != 2) $display("FAIL both_dgnt: got cycle %0d want 2", dg); else n_pass++;
    n_chk++; if (dv != 5) $display("FAIL both_drvalid: got cycle %0d want 5", dv); else n_pass++;
    n_chk++; if (ig != 7) $display("FAIL both_ifgnt: got cycle %0d want 7", ig); else n_pass++;
    n_chk++; if (iv != 10) $display("FAIL both_ifrvalid: got cycle %0d want 10", iv); else n_pass++;
  endtask

  task automatic test_store();
    int nrv = 0;
    do_reset();
    d_req = 1; d_we = 1; d_addr = 6'h08; d_wdata = 32'hDEADBEEF; d_funct3 = 3'b010;
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      if (c == 2) begin
        n_chk++;
        if ({d_gnt, if_gnt, mem_en, mem_we, mem_addr, mem_wdata, mem_funct3} !== {4'b1011, 6'h08, 32'hDEADBEEF, 3'b010})
          $display("FAIL store_access: got %b_%h_%h_%b want 1011_08_deadbeef_010",
                   {d_gnt, if_gnt, mem_en, mem_we}, mem_addr, mem_wdata, mem_funct3);
        else n_pass++;
        d_req = 0; d_we = 0;
      end
      if (c == 3) begin
        n_chk++; if ({busy, mem_en, mem_we} !== 3'b000) $display("FAIL store_c3: got %b want 000", {busy, mem_en, mem_we}); else n_pass++;
      end
      if (d_rvalid || if_rvalid) nrv++;
    end
    n_chk++; if (nrv != 0) $display("FAIL store_no_rvalid: got %0d pulses want 0", nrv); else n_pass++;
    n_chk++; if (mem[8] !== 32'hDEADBEEF) $display("FAIL store_mem: got %h want deadbeef", mem[8]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int nrv = 0;
    do_reset();
    mem[5] = 32'h00500093;
    if_req = 1; if_addr = 6'h05;
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      if (c == 2) if_req = 0;
      if (c == 3) rst = 1;
      if (c == 4) begin
        n_chk++;
        if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy, if_rdata, d_rdata, mem_addr, mem_wdata, mem_funct3} !== '0)
          $display("FAIL resetmid_outputs: got busy=%b addr=%h rdata=%h want all 0", busy, mem_addr, if_rdata);
        else n_pass++;
        rst = 0;
      end
      if (if_rvalid) nrv++;
    end
    n_chk++; if (nrv != 0) $display("FAIL resetmid_no_rvalid: got %0d pulses want 0", nrv); else n_pass++;
  endtask

  task automatic test_starvation();
    int ngnt = 0, losses = 0;
    bit exp_if;
    do_reset();
    if_req = 1; if_addr = 6'h01; d_req = 1; d_we = 0; d_addr = 6'h02; d_funct3 = 3'b010;
    for (int c = 0; c < 200 && ngnt < 12; c++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        exp_if = (losses == MAX_WAIT);
        n_chk++;
        if ({if_gnt, d_gnt} !== {exp_if, !exp_if})
          $display("FAIL starve_grant%0d: got if/d=%b%b want %b%b", ngnt, if_gnt, d_gnt, exp_if, !exp_if);
        else n_pass++;
        losses = exp_if ? 0 : losses + 1;
        ngnt++;
      end
    end
    n_chk++; if (ngnt != 12) $display("FAIL starve_timeout: got %0d grants want 12", ngnt); else n_pass++;
    if_req = 0; d_req = 0;
  endtask

  task automatic test_random();
    int next_arb = 0, gnt_cyc = -1, rv_cyc = -1, losses = 0;
    bit g_d, g_we, rv_d, win_if;
    logic [5:0] g_addr;
    logic [31:0] g_wdata, rv_data;
    logic [2:0] g_f3;
    for (int i = 0; i < 64; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    do_reset();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      n_chk++;
      if ({if_gnt, d_gnt} !== {k == gnt_cyc && !g_d, k == gnt_cyc && g_d})
        $display("FAIL rnd_gnt@%0d: got if/d=%b%b want %b%b", k, if_gnt, d_gnt, k == gnt_cyc && !g_d, k == gnt_cyc && g_d);
      else n_pass++;
      n_chk++;
      if ({if_rvalid, d_rvalid} !== {k == rv_cyc && !rv_d, k == rv_cyc && rv_d})
        $display("FAIL rnd_rvalid@%0d: got if/d=%b%b want %b%b", k, if_rvalid, d_rvalid, k == rv_cyc && !rv_d, k == rv_cyc && rv_d);
      else n_pass++;
      n_chk++;
      if (k == gnt_cyc) begin
        if ({mem_en, mem_we, mem_addr, mem_funct3} !== {1'b1, g_we, g_addr, g_f3} || (g_we && mem_wdata !== g_wdata))
          $display("FAIL rnd_mem@%0d: got en=%b we=%b a=%h f3=%b wd=%h want 1 %b %h %b %h",
                   k, mem_en, mem_we, mem_addr, mem_funct3, mem_wdata, g_we, g_addr, g_f3, g_wdata);
        else n_pass++;
      end else begin
        if ({mem_en, mem_we} !== 2'b00) $display("FAIL rnd_idle_mem@%0d: got en/we=%b%b want 00", k, mem_en, mem_we);
        else n_pass++;
      end
      if (k == rv_cyc) begin
        n_chk++;
        if ((rv_d ? d_rdata : if_rdata) !== rv_data)
          $display("FAIL rnd_rdata@%0d: got %h want %h", k, rv_d ? d_rdata : if_rdata, rv_data);
        else n_pass++;
      end
      if (!if_req || if_gnt) begin if_req = ($urandom_range(0, 2) == 0); if_addr = 6'($urandom); end
      if (!d_req || d_gnt) begin
        d_req = ($urandom_range(0, 1) == 0); d_we = $urandom_range(0, 1) == 1;
        d_addr = 6'($urandom_range(0, 7)); d_wdata = $urandom; d_funct3 = 3'($urandom);
      end
      if (k == next_arb) begin
        if (if_req || d_req) begin
          win_if = if_req && (!d_req || losses == MAX_WAIT);
          if (win_if || !if_req) losses = 0;
          else if (losses < MAX_WAIT) losses++;
          g_d = !win_if; g_addr = win_if ? if_addr : d_addr;
          g_we = !win_if && d_we; g_wdata = d_wdata; g_f3 = win_if ? 3'b010 : d_funct3;
          gnt_cyc = k + 1;
          if (g_we) begin
            ref_mem[g_addr] = g_wdata;
            next_arb = k + 2;
          end else begin
            rv_cyc = k + 2 + LAT; rv_d = g_d; rv_data = ref_mem[g_addr];
            next_arb = k + 3 + LAT;
          end
        end else begin
          losses = 0;
          next_arb = k + 1;
        end
      end
    end
    if_req = 0; d_req = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    test_reset();
    test_fetch_latency();
    test_both();
    test_store();
    test_reset_mid();
    test_starvation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
